// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory responder: the filler instruction,
// the mode encoding and the fetch-address decode.
package imem_pkg;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam logic LOAD = 1'b0;
  localparam logic RUN  = 1'b1;

  typedef enum logic {
    StLoad = LOAD,
    StRun  = RUN
  } mode_e;

  typedef struct packed {
    logic [31:0] idx;  // word index, already masked to aw bits
    logic        oor;  // address bits above the RAM window are non-zero
    logic        mis;  // byte offset within the word is non-zero
  } dec_t;

  // Split a byte address into word index and error qualifiers for an aw-bit RAM.
  function automatic dec_t decode_addr(input logic [31:0] addr, input int unsigned aw);
    dec_t d;
    d.idx = (addr >> 2) & ((32'd1 << aw) - 32'd1);
    d.oor = (addr >> (aw + 2)) != 32'd0;
    d.mis = addr[1:0] != 2'b00;
    return d;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-clock 1R1W synchronous RAM with registered read; a read and a write to the
// same word in one cycle return the old contents.
module imem_ram #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write port and registered read port; the read samples mem before this edge's write.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: answers core fetches with a fixed-latency pipelined
// read of a host-loaded RAM, returning NOPs until the program load completes.
module imem_responder #(
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned AW       = 10,
  parameter int unsigned LATENCY  = 1,
  parameter logic [31:0] NOP_INST = imem_pkg::NOP_INST
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          exIns_ren,
  input  logic [31:0]   exIns_addr,
  output logic          exIns_valid,
  output logic [31:0]   exIns_in,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data,
  input  logic          ld_done,
  output logic          run,
  output logic [31:0]   fetch_cnt,
  output logic          err_oor,
  output logic          err_mis
);

  import imem_pkg::*;

  mode_e       mode_q, mode_d;
  dec_t        dec;
  logic        accept_run;
  logic [31:0] ram_rdata;

  // Stage 1: RAM read register plus the qualifiers that pick the returned word.
  logic        s1_valid_q;
  logic        s1_nop_q;   // return NOP_INST instead of the RAM word
  logic        s1_zero_q;  // no fetch since reset: present zero
  logic [31:0] s1_data;

  logic [31:0] fetch_cnt_q;
  logic        err_oor_q, err_mis_q;
  logic        unused_idx;

  assign dec        = decode_addr(exIns_addr, AW);
  assign accept_run = exIns_ren && (mode_q == StRun);
  assign unused_idx = ^dec.idx[31:AW];

  imem_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (ld_en),
    .waddr(ld_addr),
    .wdata(ld_data),
    .re   (exIns_ren),
    .raddr(dec.idx[AW-1:0]),
    .rdata(ram_rdata)
  );

  // Mode next-state: leave LOAD on the done pulse; RUN is only left through reset.
  always_comb begin
    mode_d = mode_q;
    case (mode_q)
      StLoad:  if (ld_done) mode_d = StRun;
      StRun:   mode_d = StRun;
      default: mode_d = StLoad;
    endcase
  end

  // Mode register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      mode_q <= StLoad;
    end else begin
      mode_q <= mode_d;
    end
  end

  // Stage-1 qualifiers; mode is sampled with the request, so a fetch alongside
  // ld_done still sees LOAD.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      s1_valid_q <= 1'b0;
      s1_nop_q   <= 1'b0;
      s1_zero_q  <= 1'b1;
    end else begin
      s1_valid_q <= exIns_ren;
      if (exIns_ren) begin
        s1_nop_q  <= (mode_q != StRun) || dec.oor;
        s1_zero_q <= 1'b0;
      end
    end
  end

  // RAM output only changes on a fetch, so stage-1 data holds between requests.
  assign s1_data = s1_zero_q ? 32'd0 : (s1_nop_q ? NOP_INST : ram_rdata);

  // Fetch counter and sticky error flags, RUN-mode requests only.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      fetch_cnt_q <= 32'd0;
      err_oor_q   <= 1'b0;
      err_mis_q   <= 1'b0;
    end else if (accept_run) begin
      fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (dec.oor) err_oor_q <= 1'b1;
      if (dec.mis) err_mis_q <= 1'b1;
    end
  end

  generate
    if (LATENCY <= 1) begin : g_direct
      assign exIns_valid = s1_valid_q;
      assign exIns_in    = s1_data;
    end else begin : g_line
      logic        line_valid_q [LATENCY-1];
      logic [31:0] line_data_q  [LATENCY-1];

      // Shift line for stages 2..LATENCY; data advances only behind a valid so the
      // output holds its last response.
      always_ff @(posedge clk) begin
        if (!nrst) begin
          for (int unsigned k = 0; k < LATENCY - 1; k++) begin
            line_valid_q[k] <= 1'b0;
            line_data_q[k]  <= 32'd0;
          end
        end else begin
          line_valid_q[0] <= s1_valid_q;
          if (s1_valid_q) line_data_q[0] <= s1_data;
          for (int unsigned k = 1; k < LATENCY - 1; k++) begin
            line_valid_q[k] <= line_valid_q[k-1];
            if (line_valid_q[k-1]) line_data_q[k] <= line_data_q[k-1];
          end
        end
      end

      assign exIns_valid = line_valid_q[LATENCY-2];
      assign exIns_in    = line_data_q[LATENCY-2];
    end
  endgenerate

  assign run       = (mode_q == StRun);
  assign fetch_cnt = fetch_cnt_q;
  assign err_oor   = err_oor_q;
  assign err_mis   = err_mis_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: two instances (LATENCY 1 and 3) share stimulus;
// each response is checked for data and for arrival cycle.
module tb_imem_responder;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        nrst, ren, ld_en, ld_done;
  logic [31:0] addr, ld_data;
  logic [9:0]  ld_addr;

  logic        v1, v3, run1, run3, oor1, oor3, mis1, mis3;
  logic [31:0] d1, d3, cnt1, cnt3;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          stamp;
    logic [31:0] data;
  } resp_t;

  resp_t r1_q[$];
  resp_t r3_q[$];
  int    iss_q[$];

  imem_responder #(.DEPTH(1024), .AW(10), .LATENCY(1), .NOP_INST(NOP)) u_dut1 (
    .clk(clk), .nrst(nrst), .exIns_ren(ren), .exIns_addr(addr),
    .exIns_valid(v1), .exIns_in(d1), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .run(run1), .fetch_cnt(cnt1),
    .err_oor(oor1), .err_mis(mis1)
  );

  imem_responder #(.DEPTH(1024), .AW(10), .LATENCY(3), .NOP_INST(NOP)) u_dut3 (
    .clk(clk), .nrst(nrst), .exIns_ren(ren), .exIns_addr(addr),
    .exIns_valid(v3), .exIns_in(d3), .ld_en(ld_en), .ld_addr(ld_addr),
    .ld_data(ld_data), .ld_done(ld_done), .run(run3), .fetch_cnt(cnt3),
    .err_oor(oor3), .err_mis(mis3)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every response with the cycle it was seen in.
  always @(negedge clk) begin
    if (v1) r1_q.push_back('{cyc, d1});
    if (v3) r3_q.push_back('{cyc, d3});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] a);
    iss_q.push_back(cyc);
    ren  = 1'b1;
    addr = a;
    @(negedge clk);
    ren  = 1'b0;
  endtask

  task automatic wr(input logic [9:0] idx, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = idx;
    ld_data = data;
    @(negedge clk);
    ld_en   = 1'b0;
  endtask

  // Pop the oldest issued fetch and its response from each instance.
  task automatic expect_resp(input string tag, input logic [31:0] exp);
    int    iss;
    resp_t r;
    if (iss_q.size() == 0) begin
      check({tag, " issued"}, 32'd0, 32'd1);
      return;
    end
    iss = iss_q.pop_front();
    if (r1_q.size() == 0) begin
      check({tag, " L1 present"}, 32'd0, 32'd1);
    end else begin
      r = r1_q.pop_front();
      check({tag, " L1 data"}, r.data, exp);
      check({tag, " L1 cycle"}, 32'(r.stamp), 32'(iss + 1));
    end
    if (r3_q.size() == 0) begin
      check({tag, " L3 present"}, 32'd0, 32'd1);
    end else begin
      r = r3_q.pop_front();
      check({tag, " L3 data"}, r.data, exp);
      check({tag, " L3 cycle"}, 32'(r.stamp), 32'(iss + 3));
    end
  endtask

  task automatic check_state(input string tag, input logic exp_run, input logic [31:0] exp_cnt,
                             input logic exp_oor, input logic exp_mis);
    check({tag, " run"}, 32'({run1, run3}), 32'({exp_run, exp_run}));
    check({tag, " cnt1"}, cnt1, exp_cnt);
    check({tag, " cnt3"}, cnt3, exp_cnt);
    check({tag, " flags"}, 32'({oor1, mis1, oor3, mis3}),
          32'({exp_oor, exp_mis, exp_oor, exp_mis}));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    nrst = 1'b0; ren = 1'b0; addr = 32'd0;
    ld_en = 1'b0; ld_addr = 10'd0; ld_data = 32'd0; ld_done = 1'b0;
    idle(2);
    nrst = 1'b1;

    // Reset state
    check("rst valid", 32'({v1, v3}), 32'd0);
    check("rst data1", d1, 32'd0);
    check("rst data3", d3, 32'd0);
    check_state("rst", 1'b0, 32'd0, 1'b0, 1'b0);

    // LOAD mode returns NOP and does not count
    wr(10'd0, 32'h00500093);
    fetch(32'h0);
    idle(5);
    expect_resp("load nop", NOP);
    check_state("load", 1'b0, 32'd0, 1'b0, 1'b0);

    // Program load; fetch alongside ld_done still sees LOAD
    wr(10'd1, 32'h00a00113);
    wr(10'd2, 32'h002081b3);
    wr(10'd3, 32'h0000006f);
    ld_done = 1'b1;
    fetch(32'h0);
    ld_done = 1'b0;
    check("run rise", 32'({run1, run3}), 32'd3);
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    fetch(32'hC);
    idle(5);
    expect_resp("done nop", NOP);
    expect_resp("run w0", 32'h00500093);
    expect_resp("run w1", 32'h00a00113);
    expect_resp("run w2", 32'h002081b3);
    expect_resp("run w3", 32'h0000006f);
    check_state("run4", 1'b1, 32'd4, 1'b0, 1'b0);

    // ld_done in RUN has no effect
    ld_done = 1'b1;
    idle(1);
    ld_done = 1'b0;
    check("done in run", 32'({run1, run3}), 32'd3);

    // Out of range, then misaligned; flags are sticky
    fetch(32'h00001000);
    idle(5);
    expect_resp("oor", NOP);
    check_state("oor", 1'b1, 32'd5, 1'b1, 1'b0);
    fetch(32'h6);
    idle(5);
    expect_resp("mis", 32'h00a00113);
    check_state("mis", 1'b1, 32'd6, 1'b1, 1'b1);

    // Read-before-write, then the new word
    ld_en = 1'b1; ld_addr = 10'd2; ld_data = 32'hDEADBEEF;
    fetch(32'h8);
    ld_en = 1'b0;
    fetch(32'h8);
    idle(5);
    expect_resp("rbw old", 32'h002081b3);
    expect_resp("rbw new", 32'hDEADBEEF);
    check_state("rbw", 1'b1, 32'd8, 1'b1, 1'b1);

    // Idle: no valid, data holds
    check("hold valid", 32'({v1, v3}), 32'd0);
    check("hold data1", d1, 32'hDEADBEEF);
    check("hold data3", d3, 32'hDEADBEEF);

    // Counter wrap via back-door
    force u_dut1.fetch_cnt_q = 32'hFFFFFFFF;
    force u_dut3.fetch_cnt_q = 32'hFFFFFFFF;
    #1;
    release u_dut1.fetch_cnt_q;
    release u_dut3.fetch_cnt_q;
    @(negedge clk);
    fetch(32'h0);
    idle(5);
    expect_resp("wrap", 32'h00500093);
    check("wrap cnt1", cnt1, 32'd0);
    check("wrap cnt3", cnt3, 32'd0);

    // Reset with fetches in flight: nothing may emerge afterwards
    fetch(32'h0);
    fetch(32'h4);
    fetch(32'h8);
    nrst = 1'b0;
    idle(1);
    nrst = 1'b1;
    r1_q.delete();
    r3_q.delete();
    iss_q.delete();
    idle(6);
    check("flush L1", 32'(r1_q.size()), 32'd0);
    check("flush L3", 32'(r3_q.size()), 32'd0);
    check("flush valid", 32'({v1, v3}), 32'd0);
    check_state("flush", 1'b0, 32'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_responder.md
Name: imem_responder

Overview:
- Instruction-memory responder for the core's external fetch port. It answers the core's fetch requests (exIns_ren, exIns_addr) with the matching instruction word (exIns_valid, exIns_in).
- Holds a DEPTH-word instruction RAM with a fixed-latency, fully pipelined read path. The RAM is preloaded through a host load port.
- A LOAD/RUN mode machine gates fetches: the core receives NOPs until the program load completes.
- Sits at top level beside core, with its fetch outputs wired directly to the core's ex-instruction inputs.

Parameters:
- DEPTH, 1024, instruction words in RAM; power of 2.
- AW, 10, word-index width; equals log2(DEPTH).
- LATENCY, 1, cycles from accepted request to exIns_valid; legal range 1..4.
- NOP_INST, 32'h00000013, word returned in LOAD mode and for out-of-range fetches (addi x0,x0,0).

Ports:
- clk  in  1  clock, rising edge.
- nrst  in  1  reset; synchronous, active-low.
- exIns_ren  in  1  fetch request from core; one request accepted per cycle, never back-pressured.
- exIns_addr  in  32  byte address of the fetch.
- exIns_valid  out  1  response valid, exactly LATENCY cycles after the request.
- exIns_in  out  32  instruction word returned to core.
- ld_en  in  1  host write strobe.
- ld_addr  in  AW  word index to write.
- ld_data  in  32  word to write.
- ld_done  in  1  one-cycle pulse ending the load phase.
- run  out  1  1 while in RUN mode.
- fetch_cnt  out  32  count of fetches accepted in RUN mode; wraps.
- err_oor  out  1  sticky: a RUN-mode fetch was out of range.
- err_mis  out  1  sticky: a RUN-mode fetch had addr[1:0]!=0.

Behaviour:
- Reset (nrst==0 at a clk edge):
  - mode=LOAD; run=0.
  - exIns_valid=0, exIns_in=0, fetch_cnt=0, err_oor=0, err_mis=0.
  - All pipeline valid bits cleared.
  - RAM contents are not reset.
- Reset mid-operation: every in-flight response is dropped; no valid appears after reset deasserts.
- Mode FSM:
  - LOAD -> RUN on ld_done==1. run rises the cycle after the pulse.
  - RUN -> LOAD only via reset.
  - ld_done in RUN is ignored.
- Load port:
  - ld_en writes RAM[ld_addr]=ld_data at the clk edge.
  - Honoured in both modes, so self-modifying reload is allowed.
- Request decode:
  - word index = exIns_addr[AW+1:2].
  - Out of range when exIns_addr[31:AW+2] != 0.
  - Misaligned when addr[1:0] != 0: the low bits are ignored and the word at the index is returned.
- Pipeline:
  - A request accepted at edge t produces exIns_valid=1 with data for cycles t+LATENCY..t+LATENCY+1; i.e. stage-LATENCY registers update at edge t+LATENCY.
  - Back-to-back requests give back-to-back valids, in order and without gaps.
  - With exIns_ren==0, exIns_valid=0 LATENCY cycles later and exIns_in holds its last value.
- Data selection, captured at the request edge:
  - LOAD mode: NOP_INST.
  - RUN mode, out of range: NOP_INST, and err_oor is set.
  - Otherwise: the RAM word.
- RAM read uses one registered read (stage 1). Stages 2..LATENCY are a shift line of {valid, data}.
- Same-cycle ld_en and fetch to the same index: read-before-write. The fetch returns the old word; the new word is visible to fetches from the next cycle.
- Mode sampling: the mode is sampled when the request is accepted. A fetch in the same cycle as ld_done still returns NOP.
- fetch_cnt: +1 per accepted RUN-mode request; 32'hFFFFFFFF wraps to 0.
- Error flags: sticky until reset; set only in RUN mode. One fetch may set both flags.

Decomposition:
- Shared package imem_pkg:
  - NOP_INST constant.
  - Mode encoding localparams: LOAD=1'b0, RUN=1'b1.
  - Helper function for address decode (word index, out-of-range, misaligned).
- Sub-module imem_ram: single-clock 1R1W synchronous RAM, read-before-write, DEPTH x 32.
- The delay line and FSM stay in imem_responder.

Test Plan:
- Reset/LOAD: fetch addr 0x0 in LOAD with RAM[0]=0x00500093 -> exIns_valid after LATENCY cycles with exIns_in=0x00000013; fetch_cnt=0.
- Load then run: write RAM[0..3]=0x00500093,0x00a00113,0x002081b3,0x0000006f; pulse ld_done; fetch 0x0,0x4,0x8,0xC back-to-back -> four consecutive valids returning those words in order; fetch_cnt=4.
- Out of range / misaligned: in RUN, fetch 0x00001000 -> 0x00000013 and err_oor=1. Fetch 0x6 -> RAM[1] returned and err_mis=1. Both flags stay high.
- Read-before-write: same cycle, ld_en to index 2 with 0xDEADBEEF and fetch 0x8 -> old word returned; fetch 0x8 the next cycle -> 0xDEADBEEF.
- Reset mid-stream: LATENCY=3, issue 3 fetches, assert nrst=0 one cycle -> no exIns_valid afterwards; run=0; counters and flags are 0.
- Wrap: force fetch_cnt to 0xFFFFFFFF (back-door), one RUN fetch -> fetch_cnt=0.
